// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Latches a 32-bit hex value tear-free at frame boundaries and scans one nibble per slot.
module sevenseg_scan_ctrl #(
   parameter int unsigned NDIGITS      = 8,
   parameter int unsigned SLOT_CYCLES  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] value,
   input  logic        load,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  dp,
   output logic [7:0]  digitselect,
   output logic [7:0]  segments,
   output logic        frame_start
);

   localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [2:0]    IDX_LAST   = 3'(NDIGITS - 1);

   typedef enum logic {StBlank, StDrive} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [31:0]    pending_q, pending_d;
   logic [31:0]    shadow_q, shadow_d;
   logic           started_q, started_d;
   logic [7:0]     digitselect_d, segments_d;
   logic           frame_start_d;
   logic           slot_end, frame_end;
   logic [3:0]     nibble;

   // Active-low a..g
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      unique case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   assign slot_end  = (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);
   assign nibble    = shadow_q[{idx_q, 2'b00} +: 4];

   always_comb begin
      cnt_d         = slot_end ? '0 : cnt_q + CW'(1);
      idx_d         = idx_q;
      state_d       = state_q;
      pending_d     = load ? value : pending_q;
      shadow_d      = shadow_q;
      started_d     = started_q | frame_end;
      frame_start_d = started_q && (cnt_q == '0) && (idx_q == 3'd0);
      digitselect_d = 8'hFF;
      segments_d    = 8'hFF;

      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end

      // A load coinciding with the frame boundary bypasses pending
      if (frame_end) begin
         shadow_d = load ? value : pending_q;
      end

      unique case (state_q)
         StBlank: if (cnt_q == BLANK_LAST) state_d = StDrive;
         StDrive: if (slot_end) state_d = StBlank;
         default: state_d = StBlank;
      endcase

      if (state_q == StDrive && digit_en[idx_q]) begin
         digitselect_d = ~(8'd1 << idx_q);
         segments_d    = {hex_to_seg(nibble), ~dp[idx_q]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StBlank;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         pending_q   <= 32'd0;
         shadow_q    <= 32'd0;
         started_q   <= 1'b0;
         digitselect <= 8'hFF;
         segments    <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         shadow_q    <= shadow_d;
         started_q   <= started_d;
         digitselect <= digitselect_d;
         segments    <= segments_d;
         frame_start <= frame_start_d;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios plus random loads/enables, checked every
// cycle against a time-indexed behavioural model of the scan.
module tb_sevenseg_scan_ctrl;

   localparam int unsigned ND    = 8;
   localparam int unsigned SC    = 8;
   localparam int unsigned BC    = 2;
   localparam int unsigned FRAME = ND * SC;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] value = 32'd0;
   logic        load = 1'b0;
   logic [7:0]  digit_en = 8'hFF;
   logic [7:0]  dp = 8'h00;
   logic [7:0]  digitselect;
   logic [7:0]  segments;
   logic        frame_start;

   sevenseg_scan_ctrl #(
      .NDIGITS     (ND),
      .SLOT_CYCLES (SC),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .value      (value),
      .load       (load),
      .digit_en   (digit_en),
      .dp         (dp),
      .digitselect(digitselect),
      .segments   (segments),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Model state: t = cycles since reset release
   int unsigned t = 0;
   logic [31:0] m_pending = 32'd0;
   logic [31:0] m_shadow  = 32'd0;
   logic [7:0]  exp_ds, exp_seg;
   logic        exp_fs;

   // a..g active-low glyphs for 0..F
   logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s at t=%0d: got %h want %h", tag, t, got, want);
   endtask

   task automatic model_expect();
      int unsigned ph  = t % SC;
      int unsigned dig = (t / SC) % ND;
      logic [3:0]  nib = 4'(m_shadow >> (4 * dig));
      exp_fs = (t % FRAME == 0) && (t >= FRAME);
      if (ph < BC || !digit_en[dig]) begin
         exp_ds  = 8'hFF;
         exp_seg = 8'hFF;
      end else begin
         exp_ds  = ~(8'd1 << dig);
         exp_seg = {glyph[nib], ~dp[dig]};
      end
   endtask

   task automatic step();
      model_expect();
      if (t % FRAME == FRAME - 1) m_shadow = load ? value : m_pending;
      if (load) m_pending = value;
      t++;
      @(posedge clk);
      #1;
      check("digitselect", digitselect, exp_ds);
      check("segments", segments, exp_seg);
      check("frame_start", frame_start, exp_fs);
      check("onehot", ($countones(~digitselect) <= 1), 1);
   endtask

   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_digitselect", digitselect, 8'hFF);
      check("rst_segments", segments, 8'hFF);
      check("rst_frame_start", frame_start, 0);
      reset_n   = 1'b1;
      t         = 0;
      m_pending = 32'd0;
      m_shadow  = 32'd0;
   endtask

   task automatic pulse_load(input logic [31:0] v);
      value = v;
      load  = 1'b1;
      step();
      load  = 1'b0;
      value = $urandom;
   endtask

   initial begin
      do_reset(5);

      // Idle frame of zeros, then a mid-frame load shown only from the next frame
      repeat (20) step();
      pulse_load(32'h0123ABCD);
      while (t < 2 * FRAME) step();

      // Bypass: a stale pending value is overridden by a load on the boundary cycle
      repeat (3) step();
      pulse_load(32'h12345678);
      while (t % FRAME != FRAME - 1) step();
      pulse_load(32'hFFFFFFFF);
      repeat (FRAME) step();

      // Enables and decimal points
      digit_en = 8'h05;
      dp       = 8'h04;
      pulse_load(32'h00000888);
      while (t % FRAME != 0) step();
      repeat (FRAME) step();

      // Random loads, enables and decimal points
      for (int i = 0; i < 400; i++) begin
         step();
         if ($urandom_range(0, 15) == 0) begin
            value = $urandom;
            load  = 1'b1;
         end else begin
            load = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) digit_en = 8'($urandom);
         if ($urandom_range(0, 9) == 0) dp = 8'($urandom);
      end
      load = 1'b0;

      // Reset asserted mid-DRIVE in slot 4, cycle 5
      digit_en = 8'hFF;
      dp       = 8'h00;
      while (t % FRAME != 4 * SC + 5) step();
      check("pre_rst_drive", digitselect, 8'hEF);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_digitselect", digitselect, 8'hFF);
      check("async_segments", segments, 8'hFF);
      do_reset(3);
      repeat (FRAME + 10) step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
